// File: rtl/machine_d_sequencer_if.sv
// Handshake and data bundle between a host/bench and machine_d_sequencer.
// Optional macro SEQ_REPEAT_EN adds the repeat_mode request line.
// Timing contract: start, stop, pattern, length, f_in, s_in and repeat_mode are
// sampled on the rising clock edge. Every sequencer output is registered and
// changes only just after a rising edge. start is a request that is honoured
// only in IDLE and is never queued. done is a single-cycle completion pulse and
// needs no acknowledge.
// repeat_mode carries the "repeat" request ("repeat" is a reserved word).
interface machine_d_sequencer_if #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
);
  logic             start;
  logic             stop;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] length;
  logic             f_in;
  logic [2:0]       s_in;
`ifdef SEQ_REPEAT_EN
  logic             repeat_mode;
`endif
  logic             x;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] f_count;
  logic [2:0]       last_s;
  logic [1:0]       dbg_state;

  modport master (
    output start, stop, pattern, length, f_in, s_in,
`ifdef SEQ_REPEAT_EN
    output repeat_mode,
`endif
    input  x, busy, done, f_count, last_s, dbg_state
  );

  modport slave (
    input  start, stop, pattern, length, f_in, s_in,
`ifdef SEQ_REPEAT_EN
    input  repeat_mode,
`endif
    output x, busy, done, f_count, last_s, dbg_state
  );
endinterface

// File: rtl/machine_d_sequencer.sv
// Test-pattern controller for a 1-bit-input FSM. It shifts a programmed pattern
// onto x (LSB first, HOLD clocks per bit), drives x low for DRAIN clocks, then
// pulses done. While busy it counts the clocks on which F is high, and it
// captures S on the final busy clock.
// Optional macro SEQ_REPEAT_EN: the pattern wraps while repeat_mode is high.
module machine_d_sequencer #(
  parameter int PAT_W = 16,
  parameter int HOLD  = 2,
  parameter int DRAIN = 2,
  parameter int CNT_W = 8
) (
  input logic                   CLK,
  input logic                   RESET,
  machine_d_sequencer_if.slave  bus
);
  localparam int LEN_W  = $clog2(PAT_W + 1);
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int DRN_W  = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [HOLD_W-1:0] r_hold;
  logic [DRN_W-1:0] r_drn;
  logic             r_x;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_f_count;
  logic [2:0]       r_last_s;

  logic [LEN_W-1:0] w_len_clamped;
  logic [LEN_W-1:0] w_next_idx;
  logic             w_hold_end;
  logic             w_last_bit;
  logic             w_drain_end;
  logic             w_repeat;
  logic             w_f_sat;

`ifdef SEQ_REPEAT_EN
  assign w_repeat = bus.repeat_mode;
`else
  assign w_repeat = 1'b0;
`endif

  // Requested lengths beyond the pattern width are clamped to the full width.
  assign w_len_clamped = (int'(bus.length) > PAT_W) ? LEN_W'(PAT_W) : bus.length;
  assign w_next_idx    = r_idx + LEN_W'(1);
  assign w_hold_end    = (int'(r_hold) == HOLD - 1);
  assign w_last_bit    = (w_next_idx == r_len);
  assign w_drain_end   = (int'(r_drn) == DRAIN - 1);
  assign w_f_sat       = (r_f_count == {CNT_W{1'b1}});

  // Sequencer FSM. Every output is a register that is updated together with the state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_hold    <= '0;
      r_drn     <= '0;
      r_x       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_f_count <= '0;
      r_last_s  <= 3'd0;
    end else begin
      r_done <= 1'b0;
      // The F count covers exactly the clocks on which busy is high.
      if (r_busy && bus.f_in && !w_f_sat) begin
        r_f_count <= r_f_count + CNT_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          // start takes priority over stop here, because stop means nothing in IDLE.
          if (bus.start) begin
            r_pat     <= bus.pattern;
            r_len     <= w_len_clamped;
            r_idx     <= '0;
            r_hold    <= '0;
            r_drn     <= '0;
            r_f_count <= '0;
            if (w_len_clamped == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRIVE;
              r_busy  <= 1'b1;
              r_x     <= bus.pattern[0];
            end
          end
        end
        S_DRIVE: begin
          if (bus.stop) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_x      <= 1'b0;
            r_last_s <= bus.s_in;
          end else if (w_hold_end) begin
            r_hold <= '0;
            if (!w_last_bit) begin
              r_idx <= w_next_idx;
              r_x   <= r_pat[w_next_idx];
            end else if (w_repeat) begin
              r_idx <= '0;
              r_x   <= r_pat[0];
            end else if (DRAIN > 0) begin
              r_state <= S_DRAIN;
              r_drn   <= '0;
              r_x     <= 1'b0;
            end else begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_x      <= 1'b0;
              r_last_s <= bus.s_in;
            end
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        S_DRAIN: begin
          if (bus.stop || w_drain_end) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_x      <= 1'b0;
            r_last_s <= bus.s_in;
          end else begin
            r_drn <= r_drn + DRN_W'(1);
          end
        end
        S_DONE: begin
          // A start that arrives here is dropped, not queued.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.x         = r_x;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.f_count   = r_f_count;
  assign bus.last_s    = r_last_s;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_machine_d_sequencer.sv
// Bench for machine_d_sequencer. A second instance with CNT_W=3 receives the
// same stimulus so that the count can be driven into saturation.
// The expected x, busy, done, f_count and last_s values are computed directly
// from the run geometry: x is pattern[c/HOLD] for c < len*HOLD, and busy lasts
// len*HOLD+DRAIN clocks.
module tb_machine_d_sequencer;
  localparam int PAT_W = 16;
  localparam int HOLD  = 2;
  localparam int DRAIN = 2;
  localparam int CNT_W = 8;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_last_s = 3'd0;

  machine_d_sequencer_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();
  machine_d_sequencer_if #(.PAT_W(PAT_W), .CNT_W(3))     bus_s ();

  machine_d_sequencer #(.PAT_W(PAT_W), .HOLD(HOLD), .DRAIN(DRAIN), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );
  machine_d_sequencer #(.PAT_W(PAT_W), .HOLD(HOLD), .DRAIN(DRAIN), .CNT_W(3)) dut_s (
    .CLK(CLK), .RESET(RESET), .bus(bus_s)
  );

  assign bus_s.start   = bus.start;
  assign bus_s.stop    = bus.stop;
  assign bus_s.pattern = bus.pattern;
  assign bus_s.length  = bus.length;
  assign bus_s.f_in    = bus.f_in;
  assign bus_s.s_in    = bus.s_in;
`ifdef SEQ_REPEAT_EN
  assign bus_s.repeat_mode = bus.repeat_mode;
`endif

  // clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One run. fmode selects f_in: 0 random, 1 always 0, 2 always 1.
  // stop_at and start_at give the busy cycle at which that pulse is applied (-1 = none).
  task automatic do_run(input logic [15:0] pat, input int len_req, input int stop_at,
                        input int start_at, input int fmode, input string name);
    int L;
    int B;
    int endc;
    int cnt;
    logic [15:0] pv;
    logic ex;
    L = (len_req > PAT_W) ? PAT_W : len_req;
    B = (L > 0) ? L * HOLD + DRAIN : 0;
    endc = (stop_at >= 0 && stop_at < B) ? stop_at + 1 : B;
    cnt = 0;
    pv = pat;
    bus.pattern = pat;
    bus.length = 5'(len_req);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.pattern = 16'($urandom);
    bus.length = 5'($urandom_range(1, 31));
    for (int c = 0; c < endc; c++) begin
      case (fmode)
        1: bus.f_in = 1'b0;
        2: bus.f_in = 1'b1;
        default: bus.f_in = 1'($urandom_range(0, 1));
      endcase
      bus.s_in = 3'($urandom);
      bus.stop = (c == stop_at);
      bus.start = (c == start_at);
      ex = (c < L * HOLD) ? pv[c / HOLD] : 1'b0;
      chk($sformatf("%s x c%0d", name, c), 32'(bus.x), 32'(ex));
      chk($sformatf("%s busy c%0d", name, c), 32'(bus.busy), 32'd1);
      chk($sformatf("%s done c%0d", name, c), 32'(bus.done), 32'd0);
      if (bus.f_in) cnt++;
      exp_last_s = bus.s_in;
      tick();
      bus.stop = 1'b0;
      bus.start = 1'b0;
    end
    chk({name, " done"}, 32'(bus.done), 32'd1);
    chk({name, " busy end"}, 32'(bus.busy), 32'd0);
    chk({name, " x end"}, 32'(bus.x), 32'd0);
    chk({name, " f_count"}, 32'(bus.f_count), 32'((cnt > 255) ? 255 : cnt));
    chk({name, " f_count sat3"}, 32'(bus_s.f_count), 32'((cnt > 7) ? 7 : cnt));
    chk({name, " last_s"}, 32'(bus.last_s), 32'(exp_last_s));
    // A start request arriving in DONE is dropped.
    bus.start = 1'($urandom_range(0, 1));
    bus.length = 5'($urandom_range(1, 16));
    tick();
    bus.start = 1'b0;
    chk({name, " done one-shot"}, 32'(bus.done), 32'd0);
    chk({name, " idle busy"}, 32'(bus.busy), 32'd0);
    chk({name, " f_count hold"}, 32'(bus.f_count), 32'((cnt > 255) ? 255 : cnt));
  endtask

  // directed and random steps
  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.pattern = '0;
    bus.length = '0;
    bus.f_in = 1'b0;
    bus.s_in = 3'd0;
`ifdef SEQ_REPEAT_EN
    bus.repeat_mode = 1'b0;
`endif
    #2;
    chk("rst x", 32'(bus.x), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst f_count", 32'(bus.f_count), 32'd0);
    chk("rst last_s", 32'(bus.last_s), 32'd0);
    #10 RESET = 1'b0;
    tick();

    do_run(16'h0005, 4, -1, -1, 1, "basic");
    do_run(16'($urandom), 3, -1, -1, 2, "count3");
    do_run(16'($urandom), 8, -1, -1, 2, "count8sat");
    do_run(16'hBEEF, 0, -1, -1, 0, "len0");
    do_run(16'($urandom), 20, -1, -1, 0, "len20");
    do_run(16'h00A5, 5, -1, 3, 0, "start_ignored");
    do_run(16'h0033, 6, 2, -1, 0, "abort");
    do_run(16'h0001, 1, 2, -1, 0, "abort_drain");
    for (int r = 0; r < 12; r++) begin
      int len;
      int sa;
      int ta;
      len = $urandom_range(0, 20);
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 36) : -1;
      ta = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 36) : -1;
      do_run(16'($urandom), len, sa, ta, 0, $sformatf("rand%0d", r));
    end

`ifdef SEQ_REPEAT_EN
    bus.repeat_mode = 1'b1;
    bus.pattern = 16'h0002;
    bus.length = 5'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      logic [15:0] rp;
      rp = 16'h0002;
      bus.stop = (c == 8);
      chk($sformatf("repeat x c%0d", c), 32'(bus.x), 32'(rp[(c / HOLD) % 2]));
      chk($sformatf("repeat busy c%0d", c), 32'(bus.busy), 32'd1);
      tick();
      bus.stop = 1'b0;
    end
    chk("repeat done", 32'(bus.done), 32'd1);
    chk("repeat x end", 32'(bus.x), 32'd0);
    bus.repeat_mode = 1'b0;
    tick();
`endif

    // Mid-run reset at the fifth busy clock; there must be no done pulse afterwards.
    bus.pattern = 16'hFFFF;
    bus.length = 5'd6;
    bus.f_in = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("pre-reset f_count", 32'(bus.f_count), 32'd4);
    #2 RESET = 1'b1;
    #1;
    chk("mid rst x", 32'(bus.x), 32'd0);
    chk("mid rst busy", 32'(bus.busy), 32'd0);
    chk("mid rst done", 32'(bus.done), 32'd0);
    chk("mid rst f_count", 32'(bus.f_count), 32'd0);
    chk("mid rst last_s", 32'(bus.last_s), 32'd0);
    #2 RESET = 1'b0;
    bus.f_in = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("post rst done c%0d", c), 32'(bus.done), 32'd0);
      chk($sformatf("post rst busy c%0d", c), 32'(bus.busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
